// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit, common-anode 7-segment
// display. Steps the digit number fed to an external 3-to-8 active-low
// digit-select decoder, drives the matching active-low segment pattern,
// blanks the segments for the first BLANK_CYC cycles of every digit slot to
// suppress ghosting, and double-buffers the display data so that updates only
// take effect at frame boundaries (tear-free).
//
// Parameters
//   CLK_DIV    clock cycles per digit slot (>= 2)
//   BLANK_CYC  blanked cycles at the start of each slot (0 <= BLANK_CYC < CLK_DIV)
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   load        in   1   strobe: capture data_in/dp_in/en_in into pending buffer
//   data_in     in  32   eight hex nibbles, nibble k shown on digit k
//   dp_in       in   8   decimal point per digit, 1 = lit
//   en_in       in   8   digit enable, 0 = digit blanked (slot still consumed)
//   num         out  3   digit number to the select decoder
//   seg         out  8   active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick  out  1   one-cycle pulse in the first cycle of digit 0's slot
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    output logic [2:0]  num,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int            CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_V  = CNT_W'(BLANK_CYC);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  en;
    } disp_buf_t;

    logic [CNT_W-1:0] div_cnt, div_next;
    logic [2:0]       num_next;
    state_t           state, state_next;
    logic             slot_end;
    logic             frame_wrap;

    disp_buf_t        act_buf, pend_buf, in_buf;
    logic             pend_valid;

    assign in_buf = '{data: data_in, dp: dp_in, en: en_in};

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return pat[6:0];
    endfunction

    // Next-state logic. The BLANK/SHOW state is derived from the *next* count
    // so that num and the blanking both change on the same edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        div_next   = div_cnt + 1'b1;
        num_next   = num;
        slot_end   = 1'b0;
        frame_wrap = 1'b0;
        if (div_cnt == LAST_CNT) begin
            div_next   = '0;
            num_next   = num + 3'd1;
            slot_end   = 1'b1;
            frame_wrap = (num == 3'd7);
        end
        state_next = (div_next < BLANK_V) ? BLANK : SHOW;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            num        <= 3'd0;
            state      <= BLANK;
            frame_tick <= 1'b0;
            act_buf    <= '0;
            pend_buf   <= '0;
            pend_valid <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            num        <= num_next;
            state      <= state_next;
            frame_tick <= frame_wrap;

            if (load) begin
                pend_buf   <= in_buf;
                pend_valid <= 1'b1;
            end

            // A load coinciding with the wrap edge bypasses the pending
            // buffer so it is visible in the very next frame.
            if (frame_wrap) begin
                if (load) begin
                    act_buf    <= in_buf;
                    pend_valid <= 1'b0;
                end else if (pend_valid) begin
                    act_buf    <= pend_buf;
                    pend_valid <= 1'b0;
                end
            end
        end
    end

    // Moore segment output: decoded from registered state only.
    always_comb begin
        seg = 8'hFF;
        if (state == SHOW && act_buf.en[num]) begin
            seg = {~act_buf.dp[num], hex7(act_buf.data[{num, 2'b00} +: 4])};
        end
    end

    // slot_end is kept as a named term for readability of the wrap logic.
    logic unused_ok;
    assign unused_ok = slot_end;

endmodule
